// File: rtl/branch_pkg.sv
// Shared definitions for the branch redirect slice: state encoding, widths, helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package branch_pkg;

  localparam int ADDR_WIDTH      = 32;
  localparam int STALL_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    BR_IDLE     = 2'd0,
    BR_WAIT     = 2'd1,
    BR_REDIRECT = 2'd2
  } brState_t;

  // Saturating increment for the dependency-stall counter; holds at lim.
  function automatic logic [STALL_CNT_WIDTH-1:0] satInc(
    input logic [STALL_CNT_WIDTH-1:0] v,
    input logic [STALL_CNT_WIDTH-1:0] lim
  );
    return (v >= lim) ? v : v + STALL_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/branch_stats_counter.sv
// Purpose: 32-bit event counter with increment enable, saturating at all-ones.
// Latency: count reflects an increment one edge after Inc is sampled high.
// Backpressure: none; Inc is sampled every cycle.
//
// Ports: Clk, Rst (async, active-high), Inc (count this cycle), Count (current value).
module branch_stats_counter (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Inc,
  output logic [31:0] Count
);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Count <= 32'h0;
    end else if (Inc && (Count != 32'hFFFF_FFFF)) begin
      Count <= Count + 32'd1;
    end
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// Purpose: turns an ID-stage branch resolution into PC redirect, flushes and hazard stalls.
// Latency: taken branch resolved at edge N drives PCSrc/FlushIFID during cycle N+1.
// Backpressure: stalls PC and IF/ID while the branch operands are not ready (DepStall).
//
// Ports:
//   Clk, Rst                         clock, async active-high reset
//   BrValid, BranchFlag, DepStall    branch present in ID, comparator result, operand hazard
//   BrTarget                         branch target computed in ID
//   PCSrc, PCNext                    select and registered redirect target for the PC
//   StallPC, StallIFID               hold PC and IF/ID
//   FlushIFID, FlushIDEX             squash IF/ID, bubble ID/EX
//   StallErr                         sticky: stall ran longer than MAX_STALL cycles
// Optional macro BRANCH_STATS_EN adds BrResolvedCnt, BrTakenCnt, StallCycCnt outputs.
module branch_redirect_unit
  import branch_pkg::*;
#(
  parameter int DELAY_SLOT = 0,
  parameter int MAX_STALL  = 15
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  BrValid,
  input  logic                  BranchFlag,
  input  logic                  DepStall,
  input  logic [ADDR_WIDTH-1:0] BrTarget,
  output logic                  PCSrc,
  output logic [ADDR_WIDTH-1:0] PCNext,
  output logic                  StallPC,
  output logic                  StallIFID,
  output logic                  FlushIFID,
  output logic                  FlushIDEX,
  output logic                  StallErr
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]           BrResolvedCnt,
  output logic [31:0]           BrTakenCnt,
  output logic [31:0]           StallCycCnt
`endif
);

  localparam logic [STALL_CNT_WIDTH-1:0] MaxStallC = STALL_CNT_WIDTH'(MAX_STALL);

  brState_t                   state;
  brState_t                   stateNxt;
  logic [STALL_CNT_WIDTH-1:0] stallCnt;
  logic [STALL_CNT_WIDTH-1:0] stallCntInc;

  // A branch can only be evaluated outside REDIRECT; in REDIRECT the ID
  // instruction is the wrong-path or delay-slot one and must be ignored.
  logic evalCycle;
  logic stallNow;
  logic resolveNow;
  logic takeNow;

  assign evalCycle   = ((state == BR_IDLE) || (state == BR_WAIT)) && BrValid;
  assign stallNow    = evalCycle && DepStall;
  assign resolveNow  = evalCycle && !DepStall;
  assign takeNow     = resolveNow && BranchFlag;
  assign stallCntInc = satInc(stallCnt, MaxStallC);

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= BR_IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  // Next-state logic
  always_comb begin
    stateNxt = state;
    unique case (state)
      BR_IDLE: begin
        if (stallNow) begin
          stateNxt = BR_WAIT;
        end else if (takeNow) begin
          stateNxt = BR_REDIRECT;
        end
      end
      BR_WAIT: begin
        // Upstream squash drops the pending branch without a redirect.
        if (!BrValid) begin
          stateNxt = BR_IDLE;
        end else if (!DepStall) begin
          stateNxt = BranchFlag ? BR_REDIRECT : BR_IDLE;
        end
      end
      BR_REDIRECT: stateNxt = BR_IDLE;
      default:     stateNxt = BR_IDLE;
    endcase
  end

  // Output logic; stall and redirect outputs live in disjoint states, so
  // PCSrc and StallPC can never be high together.
  always_comb begin
    PCSrc     = 1'b0;
    StallPC   = 1'b0;
    StallIFID = 1'b0;
    FlushIFID = 1'b0;
    FlushIDEX = 1'b0;
    unique case (state)
      BR_IDLE, BR_WAIT: begin
        StallPC   = stallNow;
        StallIFID = stallNow;
        FlushIDEX = stallNow;
      end
      BR_REDIRECT: begin
        PCSrc     = 1'b1;
        FlushIFID = 1'b1;
        // With a delay slot the instruction in ID is architecturally executed.
        FlushIDEX = (DELAY_SLOT == 0);
      end
      default: ;
    endcase
  end

  // Redirect target, stall counter and sticky stall error
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      PCNext   <= '0;
      stallCnt <= '0;
      StallErr <= 1'b0;
    end else begin
      if (takeNow) begin
        PCNext <= BrTarget;
      end
      if ((state == BR_WAIT) && stallNow) begin
        stallCnt <= stallCntInc;
        if (stallCntInc == MaxStallC) begin
          StallErr <= 1'b1;
        end
      end else begin
        stallCnt <= '0;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  branch_stats_counter uResolvedCnt (
    .Clk  (Clk),
    .Rst  (Rst),
    .Inc  (resolveNow),
    .Count(BrResolvedCnt)
  );

  branch_stats_counter uTakenCnt (
    .Clk  (Clk),
    .Rst  (Rst),
    .Inc  (takeNow),
    .Count(BrTakenCnt)
  );

  branch_stats_counter uStallCycCnt (
    .Clk  (Clk),
    .Rst  (Rst),
    .Inc  (state == BR_WAIT),
    .Count(StallCycCnt)
  );
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Testbench for branch_redirect_unit: one instance without and one with a delay slot,
// both driven by the same stimulus.
module tb_branch_redirect_unit;

  logic        Clk;
  logic        Rst;
  logic        BrValid;
  logic        BranchFlag;
  logic        DepStall;
  logic [31:0] BrTarget;

  logic        PCSrc, StallPC, StallIFID, FlushIFID, FlushIDEX, StallErr;
  logic [31:0] PCNext;
  logic        dsPCSrc, dsStallPC, dsStallIFID, dsFlushIFID, dsFlushIDEX, dsStallErr;
  logic [31:0] dsPCNext;
`ifdef BRANCH_STATS_EN
  logic [31:0] BrResolvedCnt, BrTakenCnt, StallCycCnt;
  logic [31:0] dsBrResolvedCnt, dsBrTakenCnt, dsStallCycCnt;
`endif

  int nChecks = 0;
  int nFails  = 0;

  branch_redirect_unit #(.DELAY_SLOT(0), .MAX_STALL(15)) dut (
    .Clk(Clk), .Rst(Rst), .BrValid(BrValid), .BranchFlag(BranchFlag),
    .DepStall(DepStall), .BrTarget(BrTarget),
    .PCSrc(PCSrc), .PCNext(PCNext), .StallPC(StallPC), .StallIFID(StallIFID),
    .FlushIFID(FlushIFID), .FlushIDEX(FlushIDEX), .StallErr(StallErr)
`ifdef BRANCH_STATS_EN
    , .BrResolvedCnt(BrResolvedCnt), .BrTakenCnt(BrTakenCnt), .StallCycCnt(StallCycCnt)
`endif
  );

  branch_redirect_unit #(.DELAY_SLOT(1), .MAX_STALL(15)) dutDs (
    .Clk(Clk), .Rst(Rst), .BrValid(BrValid), .BranchFlag(BranchFlag),
    .DepStall(DepStall), .BrTarget(BrTarget),
    .PCSrc(dsPCSrc), .PCNext(dsPCNext), .StallPC(dsStallPC), .StallIFID(dsStallIFID),
    .FlushIFID(dsFlushIFID), .FlushIDEX(dsFlushIDEX), .StallErr(dsStallErr)
`ifdef BRANCH_STATS_EN
    , .BrResolvedCnt(dsBrResolvedCnt), .BrTakenCnt(dsBrTakenCnt), .StallCycCnt(dsStallCycCnt)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic        bv, bf, ds;
    logic [31:0] tgt;
    logic        pcSrc;
    logic [31:0] pcNext;
    logic        stPc, stIfid, flIfid, flIdex, flIdexDs, err;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic bv, input logic bf, input logic ds, input logic [31:0] tgt,
    input logic pcSrc, input logic [31:0] pcNext, input logic stPc, input logic stIfid,
    input logic flIfid, input logic flIdex, input logic flIdexDs, input logic err
  );
    vec_t v;
    v.bv = bv; v.bf = bf; v.ds = ds; v.tgt = tgt;
    v.pcSrc = pcSrc; v.pcNext = pcNext; v.stPc = stPc; v.stIfid = stIfid;
    v.flIfid = flIfid; v.flIdex = flIdex; v.flIdexDs = flIdexDs; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    //                bv bf ds target         pcSrc pcNext         stPc stIf flIf flEx flExDs err
    vecs[0]  = mk(1, 1, 0, 32'h0040_0020, 0, 32'h0000_0000, 0, 0, 0, 0, 0, 0); // taken, no hazard
    vecs[1]  = mk(0, 0, 0, 32'h0000_0000, 1, 32'h0040_0020, 0, 0, 1, 1, 0, 0); // redirect
    vecs[2]  = mk(0, 0, 0, 32'h0000_0000, 0, 32'h0040_0020, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 32'h1234_5678, 0, 32'h0040_0020, 0, 0, 0, 0, 0, 0); // not taken
    vecs[4]  = mk(0, 0, 0, 32'h0000_0000, 0, 32'h0040_0020, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 1, 1, 32'hDEAD_BEE0, 0, 32'h0040_0020, 1, 1, 0, 1, 1, 0); // stall from IDLE
    vecs[6]  = mk(1, 1, 1, 32'hDEAD_BEE0, 0, 32'h0040_0020, 1, 1, 0, 1, 1, 0); // WAIT
    vecs[7]  = mk(1, 1, 1, 32'hDEAD_BEE0, 0, 32'h0040_0020, 1, 1, 0, 1, 1, 0); // WAIT
    vecs[8]  = mk(1, 1, 0, 32'h0000_1000, 0, 32'h0040_0020, 0, 0, 0, 0, 0, 0); // resolve taken
    vecs[9]  = mk(1, 1, 0, 32'hFFFF_0000, 1, 32'h0000_1000, 0, 0, 1, 1, 0, 0); // redirect, BrValid ignored
    vecs[10] = mk(1, 1, 0, 32'h0000_0040, 0, 32'h0000_1000, 0, 0, 0, 0, 0, 0); // back-to-back taken
    vecs[11] = mk(0, 0, 0, 32'h0000_0000, 1, 32'h0000_0040, 0, 0, 1, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 32'h0000_0000, 0, 32'h0000_0040, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(1, 0, 1, 32'h0000_0000, 0, 32'h0000_0040, 1, 1, 0, 1, 1, 0); // stall
    vecs[14] = mk(0, 0, 1, 32'h0000_0000, 0, 32'h0000_0040, 0, 0, 0, 0, 0, 0); // squash in WAIT
    vecs[15] = mk(0, 0, 0, 32'h0000_0000, 0, 32'h0000_0040, 0, 0, 0, 0, 0, 0);
    vecs[16] = mk(1, 0, 1, 32'h0000_0000, 0, 32'h0000_0040, 1, 1, 0, 1, 1, 0); // stall
    vecs[17] = mk(1, 0, 0, 32'h0000_0000, 0, 32'h0000_0040, 0, 0, 0, 0, 0, 0); // resolve not taken
    vecs[18] = mk(0, 0, 0, 32'h0000_0000, 0, 32'h0000_0040, 0, 0, 0, 0, 0, 0);

    Rst = 1'b1; BrValid = 1'b0; BranchFlag = 1'b0; DepStall = 1'b0; BrTarget = 32'h0;
    #2;
    chk("reset PCSrc", PCSrc, 0);
    chk("reset PCNext", PCNext, 0);
    chk("reset StallPC", StallPC, 0);
    chk("reset StallIFID", StallIFID, 0);
    chk("reset FlushIFID", FlushIFID, 0);
    chk("reset FlushIDEX", FlushIDEX, 0);
    chk("reset StallErr", StallErr, 0);
`ifdef BRANCH_STATS_EN
    chk("reset BrResolvedCnt", BrResolvedCnt, 0);
    chk("reset BrTakenCnt", BrTakenCnt, 0);
    chk("reset StallCycCnt", StallCycCnt, 0);
`endif
    nextCycle();
    Rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      BrValid = vecs[i].bv; BranchFlag = vecs[i].bf; DepStall = vecs[i].ds; BrTarget = vecs[i].tgt;
      #3;
      chk($sformatf("vec%0d PCSrc", i), PCSrc, vecs[i].pcSrc);
      chk($sformatf("vec%0d PCNext", i), PCNext, vecs[i].pcNext);
      chk($sformatf("vec%0d StallPC", i), StallPC, vecs[i].stPc);
      chk($sformatf("vec%0d StallIFID", i), StallIFID, vecs[i].stIfid);
      chk($sformatf("vec%0d FlushIFID", i), FlushIFID, vecs[i].flIfid);
      chk($sformatf("vec%0d FlushIDEX", i), FlushIDEX, vecs[i].flIdex);
      chk($sformatf("vec%0d StallErr", i), StallErr, vecs[i].err);
      chk($sformatf("vec%0d ds PCSrc", i), dsPCSrc, vecs[i].pcSrc);
      chk($sformatf("vec%0d ds PCNext", i), dsPCNext, vecs[i].pcNext);
      chk($sformatf("vec%0d ds FlushIFID", i), dsFlushIFID, vecs[i].flIfid);
      chk($sformatf("vec%0d ds FlushIDEX", i), dsFlushIDEX, vecs[i].flIdexDs);
      nextCycle();
    end

`ifdef BRANCH_STATS_EN
    chk("stats BrResolvedCnt", BrResolvedCnt, 5);
    chk("stats BrTakenCnt", BrTakenCnt, 3);
    chk("stats StallCycCnt", StallCycCnt, 5);
`endif

    // Stall overflow: 16 consecutive stall cycles, StallErr rises after the 16th.
    BrValid = 1'b0; BranchFlag = 1'b0; DepStall = 1'b0;
    Rst = 1'b1;
    #1;
    chk("rst clears PCNext", PCNext, 0);
    Rst = 1'b0;
    nextCycle();
    for (int c = 0; c < 16; c++) begin
      BrValid = 1'b1; DepStall = 1'b1; BranchFlag = 1'b1; BrTarget = 32'h0000_0800;
      #3;
      chk($sformatf("ovf c%0d StallErr", c), StallErr, 0);
      chk($sformatf("ovf c%0d StallPC", c), StallPC, 1);
      nextCycle();
    end
    #3;
    chk("ovf c16 StallErr", StallErr, 1);
    chk("ovf c16 StallPC", StallPC, 1);
    chk("ovf c16 PCSrc", PCSrc, 0);
    nextCycle();
    BranchFlag = 1'b0; DepStall = 1'b0;
    #3;
    chk("ovf resolve StallPC", StallPC, 0);
    chk("ovf resolve StallErr", StallErr, 1);
    nextCycle();
    BrValid = 1'b0;
    #3;
    chk("ovf sticky StallErr", StallErr, 1);
    chk("ovf sticky PCSrc", PCSrc, 0);
    Rst = 1'b1;
    #1;
    chk("ovf rst StallErr", StallErr, 0);
    Rst = 1'b0;
    nextCycle();

    // Reset asserted asynchronously during the REDIRECT cycle.
    BrValid = 1'b1; BranchFlag = 1'b1; DepStall = 1'b0; BrTarget = 32'h00AB_C000;
    nextCycle();
    BrValid = 1'b0; BranchFlag = 1'b0;
    #1;
    chk("midrst before PCSrc", PCSrc, 1);
    chk("midrst before PCNext", PCNext, 32'h00AB_C000);
    Rst = 1'b1;
    #1;
    chk("midrst PCSrc", PCSrc, 0);
    chk("midrst FlushIFID", FlushIFID, 0);
    chk("midrst FlushIDEX", FlushIDEX, 0);
    chk("midrst PCNext", PCNext, 0);
    nextCycle();
    Rst = 1'b0;
    #3;
    chk("midrst after PCSrc", PCSrc, 0);
    chk("midrst after FlushIFID", FlushIFID, 0);
    nextCycle();
    BrValid = 1'b1; BranchFlag = 1'b1; BrTarget = 32'h0000_0100;
    nextCycle();
    BrValid = 1'b0; BranchFlag = 1'b0;
    #3;
    chk("recover PCSrc", PCSrc, 1);
    chk("recover PCNext", PCNext, 32'h0000_0100);
    nextCycle();
    #3;
    chk("recover idle PCSrc", PCSrc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
